// File: rtl/request_conditioner_pkg.sv
// Shared definitions for the request conditioner: default data width,
// channel FSM state encodings and constant-evaluable sizing helpers.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

package request_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } chan_state_e;

  function automatic int unsigned rc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned rc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/request_channel.sv
// One request channel: synchroniser, press/release debounce, optional
// auto-repeat. pulse_c is the next-cycle pulse event for the top to register.
module request_channel
  import request_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic pulse_c,
  output logic held_o
);

  localparam int unsigned CNT_W = rc_clog2(rc_max(DEBOUNCE_CYCLES, REPEAT_DELAY)) + 1;
  localparam int unsigned REP_W = rc_clog2(rc_max(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  chan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [REP_W-1:0]       rep_q, rep_d, rep_inc;
  logic                   rep_phase_q, rep_phase_d;
  logic                   held_q;
  logic                   s, deb_done, rep_hit;

  // cnt_q is 0 in IDLE and HELD, so the first sample of a new run sees cnt_inc == 1
  assign s        = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign rep_inc  = rep_q + REP_ONE;
  assign deb_done = (cnt_inc == DEB_LAST);
  assign rep_hit  = (rep_inc == (rep_phase_q ? REP_NEXT : REP_FIRST));
  assign held_o   = held_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    rep_phase_d = rep_phase_q;
    pulse_c     = 1'b0;
    case (state_q)
      IDLE, PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (deb_done) begin
          state_d     = HELD;
          cnt_d       = '0;
          rep_d       = '0;
          rep_phase_d = 1'b0;
          pulse_c     = 1'b1;
        end else begin
          state_d = PRESS;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
          // repeat timer is frozen while a release is being debounced
          if (state_q == HELD && REPEAT_EN != 0) begin
            if (rep_hit) begin
              pulse_c     = 1'b1;
              rep_d       = '0;
              rep_phase_d = 1'b1;
            end else begin
              rep_d = rep_inc;
            end
          end
        end else if (deb_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RELEASE;
          cnt_d   = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], req_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
      held_q      <= (state_d == HELD) || (state_d == RELEASE);
    end
  end

endmodule

// File: rtl/request_conditioner.sv
// Turns asynchronous read/write request levels into clean single-cycle
// FIFO enables, with write data captured alongside the write pulse.
module request_conditioner
  import request_conditioner_pkg::*;
#(
  parameter int unsigned DATA_W          = `BIT_DEPTH,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 4,
  parameter int unsigned COLLIDE_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_read,
  input  logic              enable_write,
  input  logic [DATA_W-1:0] value_to_write,
  output logic              synchr_enable_read,
  output logic              synchr_enable_write,
  output logic [DATA_W-1:0] synchr_to_write,
  output logic              read_held,
  output logic              write_held
);

  logic              rd_pulse_c, wr_pulse_c;
  logic              rd_q, rd_d, wr_q;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] data_q;

  request_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_read (
    .clk(clk), .rst(rst), .req_i(enable_read), .pulse_c(rd_pulse_c), .held_o(read_held)
  );

  request_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_write (
    .clk(clk), .rst(rst), .req_i(enable_write), .pulse_c(wr_pulse_c), .held_o(write_held)
  );

  // write-wins: a colliding read slips one cycle; pulses are >=2 apart so one slot suffices
  always_comb begin
    rd_d      = rd_pulse_c;
    pending_d = 1'b0;
    if (COLLIDE_MODE == 32'd1) begin
      rd_d      = (rd_pulse_c && !wr_pulse_c) || pending_q;
      pending_d = rd_pulse_c && wr_pulse_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_pulse_c;
      pending_q <= pending_d;
      if (wr_pulse_c) data_q <= value_to_write;
    end
  end

  assign synchr_enable_read  = rd_q;
  assign synchr_enable_write = wr_q;
  assign synchr_to_write     = data_q;

endmodule

// File: doc/request_conditioner.md
Name: request_conditioner

Overview:
- Parametrised successor to the FIFO enable-signal organiser.
- Converts asynchronous user read and write requests (Arty7 buttons or switches) into clean, single-cycle, clock-synchronous enable pulses for the FIFO core.
- Adds over the previous generation:
  - configurable synchroniser depth;
  - press and release debouncing;
  - optional auto-repeat while a request is held;
  - selectable read/write collision policy;
  - write data captured together with the write pulse.
- Sits between board I/O and the FIFO read/write ports.

Parameters:
- DATA_W, `BIT_DEPTH, width of write data.
- SYNC_STAGES, 2, synchroniser flops per request input (legal range 2..4).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or a release (at least 1).
- REPEAT_EN, 0, 1 enables auto-repeat while a request is held.
- REPEAT_DELAY, 16, cycles from the first pulse to the first repeat pulse (at least 2).
- REPEAT_PERIOD, 4, cycles between subsequent repeat pulses (at least 2).
- COLLIDE_MODE, 0:
  - 0: read and write pulses may coincide;
  - 1: write wins and read is deferred by one cycle.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable_read, input, 1, asynchronous read request level.
- enable_write, input, 1, asynchronous write request level.
- value_to_write, input, DATA_W, write data (quasi-static).
- synchr_enable_read, output, 1, one-cycle read pulse.
- synchr_enable_write, output, 1, one-cycle write pulse.
- synchr_to_write, output, DATA_W, data registered with the write pulse.
- read_held, output, 1, debounced read level.
- write_held, output, 1, debounced write level.

Behaviour:
- Reset and clocking:
  - Single clock domain. Reset is synchronous and active-high, on rst.
  - While rst is high at an edge, the following clear: all outputs to 0, the synchroniser chains to 0, the FSMs to IDLE, all counters to 0, and the pending-read flag to 0.
  - Reset asserted mid-operation aborts any pulse or repeat. No pulse is emitted on the first cycles after release unless a new press completes debounce.
- Each channel (read, write) is independent:
  - SYNC_STAGES flop chain producing level s.
  - Debounce counter of width $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY))+1.
  - FSM with four states:
    - IDLE: s=1 → PRESS, cnt=1.
    - PRESS: s=1 increments cnt. When cnt reaches DEBOUNCE_CYCLES: emit pulse, enter HELD, clear the repeat counter. s=0 → IDLE with no pulse (glitch rejected).
    - HELD: s=0 → RELEASE, cnt=1. Otherwise, if REPEAT_EN, the repeat counter runs. A pulse is emitted when it reaches REPEAT_DELAY (first repeat) and thereafter every REPEAT_PERIOD.
    - RELEASE: s=0 increments cnt; reaching DEBOUNCE_CYCLES → IDLE. s=1 → HELD with no new pulse. The repeat counter is frozen in RELEASE and resumes on return to HELD.
  - held = 1 in HELD and RELEASE.
- Latency: number edges from 1, where edge 1 is the first edge sampling the input high. With the input held, the pulse is high for exactly the one cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6).
- Write data: synchr_to_write is loaded from value_to_write at the same edge synchr_enable_write rises, and holds until the next write pulse.
- Collision handling:
  - COLLIDE_MODE=0: both pulses are driven unchanged.
  - COLLIDE_MODE=1: if both channels pulse in one cycle, the write pulse goes out and pending_read is set. The read pulse is issued the next cycle and pending_read clears.
  - Pulses per channel are at least 2 cycles apart, so at most one read is pending at a time.
- Outputs are registered; there is no combinational input-to-output path.

Decomposition:
- The shared header supplies `BIT_DEPTH, the FSM state encodings (IDLE=2'd0, PRESS=2'd1, HELD=2'd2, RELEASE=2'd3) and a clog2 helper. None of these are redefined locally.
- One sub-module, request_channel:
  - contents: synchroniser, debounce/repeat counters, FSM;
  - outputs: pulse and held;
  - instantiated twice, for read and write.
- The top level holds the data capture register and the collision logic.

Test Plan (default parameters unless stated; value_to_write=7):
- Reset then hold enable_write high → synchr_enable_write high for exactly one cycle after edge 6, synchr_to_write=7, write_held=1. No further pulse while held with REPEAT_EN=0.
- enable_read high for 3 cycles, then low → no synchr_enable_read pulse and read_held stays 0. A subsequent 8-cycle press → exactly one pulse.
- Hold write, then a 2-cycle low glitch while held → write_held stays 1 and no second pulse. A 6-cycle low period → write_held drops after debounce.
- REPEAT_EN=1, write held 40 cycles after the first pulse → repeat pulses at +16, +20, +24, +28, +32, +36, +40. Data is recaptured each pulse; change value_to_write to 9 and observe 9 on later pulses.
- COLLIDE_MODE=1 with read and write pressed on the same edge → write pulse at edge 6, read pulse at edge 7. With COLLIDE_MODE=0 → both at edge 6.
- rst asserted for one edge during PRESS (edge 4) → no pulse at edge 6, and held outputs = 0. A full debounce restarts from the first post-reset sampling edge.
